// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary-neural-net dot-product CXU.
package bnn_pkg;

    localparam int unsigned BNN_MAX_DATA_W  = 64;
    localparam int unsigned BNN_MAX_STATE_W = 4;
    localparam int unsigned BNN_MAX_POP_W   = 7;

    localparam logic [1:0] BNN_FUNC_DOT   = 2'd0;
    localparam logic [1:0] BNN_FUNC_ACC   = 2'd1;
    localparam logic [1:0] BNN_FUNC_READ  = 2'd2;
    localparam logic [1:0] BNN_FUNC_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        BNN_OK        = 2'd0,
        BNN_ERR_FUNC  = 2'd1,
        BNN_ERR_STATE = 2'd2
    } bnn_status_t;

    // Stage-1 payload, sized for the largest legal configuration.
    typedef struct packed {
        logic [1:0]                 func;
        logic [BNN_MAX_STATE_W-1:0] state;
        bnn_status_t                status;
        logic [BNN_MAX_POP_W-1:0]   pop;
    } bnn_s1_t;

    // Pairwise adder-tree popcount; narrower vectors are zero-extended by the caller.
    function automatic logic [BNN_MAX_POP_W-1:0] bnn_popcount(input logic [BNN_MAX_DATA_W-1:0] v);
        logic [BNN_MAX_POP_W-1:0] lvl [BNN_MAX_DATA_W];
        for (int i = 0; i < int'(BNN_MAX_DATA_W); i++) begin
            lvl[i] = BNN_MAX_POP_W'(v[i]);
        end
        for (int span = int'(BNN_MAX_DATA_W) / 2; span >= 1; span = span / 2) begin
            for (int i = 0; i < span; i++) begin
                lvl[i] = lvl[2*i] + lvl[2*i+1];
            end
        end
        return lvl[0];
    endfunction

endpackage

// File: rtl/bnn_popcnt_reduce.sv
// XNOR of activation and weight vectors followed by a popcount reduction.
module bnn_popcnt_reduce
    import bnn_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned POP_W = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] w,
    output logic [POP_W-1:0]  pop
);

    logic [DATA_W-1:0] agree;

    assign agree = ~(a ^ w);
    assign pop   = POP_W'(bnn_popcount(BNN_MAX_DATA_W'(agree)));

endmodule

// File: rtl/bnn_acc_l2_cxu.sv
// Two-stage CXU-L2 XNOR-popcount unit with per-context signed accumulators.
module bnn_acc_l2_cxu
    import bnn_pkg::*;
#(
    parameter int unsigned CXU_DATA_W     = 32,
    parameter int unsigned CXU_N_STATES   = 4,
    parameter int unsigned CXU_STATE_ID_W = 2,
    parameter int unsigned CXU_FUNC_ID_W  = 3,
    parameter int unsigned ACC_W          = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CXU_STATE_ID_W-1:0] req_state,
    input  logic [CXU_FUNC_ID_W-1:0]  req_func,
    input  logic [CXU_DATA_W-1:0]     req_data0,
    input  logic [CXU_DATA_W-1:0]     req_data1,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [1:0]                resp_status,
    output logic [CXU_DATA_W-1:0]     resp_data
);

    localparam int unsigned POP_W = $clog2(CXU_DATA_W) + 1;

    logic                  out_en;
    logic                  s1_en;
    logic                  s1_valid;
    bnn_s1_t               s1_q;
    bnn_s1_t               s1_d;
    logic [POP_W-1:0]      pop;

    logic [ACC_W-1:0]      acc [CXU_N_STATES];
    logic [ACC_W-1:0]      acc_cur;
    logic [ACC_W-1:0]      dot_term;
    logic [ACC_W-1:0]      acc_sum;
    logic [ACC_W-1:0]      acc_wdata;
    logic                  acc_we;
    bnn_status_t           out_status;
    logic [CXU_DATA_W-1:0] out_data;

    // Ready depends only on pipeline occupancy and resp_ready.
    assign out_en    = !resp_valid || resp_ready;
    assign s1_en     = !s1_valid || out_en;
    assign req_ready = s1_en;

    bnn_popcnt_reduce #(
        .DATA_W (CXU_DATA_W)
    ) u_popcnt (
        .a   (req_data0),
        .w   (req_data1),
        .pop (pop)
    );

    // Stage-1 decode: classify errors up front so stage 2 only has to execute.
    always_comb begin
        s1_d        = '0;
        s1_d.func   = req_func[1:0];
        s1_d.state  = BNN_MAX_STATE_W'(req_state);
        s1_d.pop    = BNN_MAX_POP_W'(pop);
        s1_d.status = BNN_OK;
        if (32'(req_func) >= 32'd4) begin
            s1_d.status = BNN_ERR_FUNC;
        end else if (req_func[1:0] != BNN_FUNC_DOT && 32'(req_state) >= 32'(CXU_N_STATES)) begin
            s1_d.status = BNN_ERR_STATE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_en) begin
            s1_valid <= req_valid;
            if (req_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    always_comb begin
        acc_cur = '0;
        for (int unsigned i = 0; i < CXU_N_STATES; i++) begin
            if (s1_q.state == BNN_MAX_STATE_W'(i)) begin
                acc_cur = acc[i];
            end
        end
    end

    // Signed dot term 2*pop - DATA_W, formed modulo 2^ACC_W.
    assign dot_term = ACC_W'({s1_q.pop, 1'b0}) - ACC_W'(CXU_DATA_W);
    assign acc_sum  = acc_cur + dot_term;

    always_comb begin
        out_status = s1_q.status;
        out_data   = '0;
        acc_we     = 1'b0;
        acc_wdata  = acc_cur;
        if (s1_q.status == BNN_OK) begin
            case (s1_q.func)
                BNN_FUNC_DOT: begin
                    out_data = CXU_DATA_W'(s1_q.pop);
                end
                BNN_FUNC_ACC: begin
                    acc_we    = 1'b1;
                    acc_wdata = acc_sum;
                    out_data  = CXU_DATA_W'($signed(acc_sum));
                end
                BNN_FUNC_READ: begin
                    out_data = CXU_DATA_W'($signed(acc_cur));
                end
                default: begin
                    acc_we    = 1'b1;
                    acc_wdata = '0;
                    out_data  = CXU_DATA_W'($signed(acc_cur));
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_status <= 2'b00;
            resp_data   <= '0;
        end else if (out_en) begin
            resp_valid <= s1_valid;
            if (s1_valid) begin
                resp_status <= out_status;
                resp_data   <= out_data;
            end
        end
    end

    // Accumulators are touched only at the advance point, so request order is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CXU_N_STATES; i++) begin
                acc[i] <= '0;
            end
        end else if (out_en && s1_valid && acc_we) begin
            for (int unsigned i = 0; i < CXU_N_STATES; i++) begin
                if (s1_q.state == BNN_MAX_STATE_W'(i)) begin
                    acc[i] <= acc_wdata;
                end
            end
        end
    end

endmodule
